// File: rtl/mc_chroma_filter_feeder.sv
// mc_chroma_filter_feeder
//   Fetch/sequencing shell around one row of external chroma interpolation
//   filters. On start it reads H+3 reference rows, hands each row to the W
//   horizontal filters, keeps the last four horizontal results as a vertical
//   window for the W vertical filters, and writes H predicted rows.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   start_i              one-cycle start pulse, only honoured in IDLE
//   frac_x_i, frac_y_i   fractional MV, latched at start
//   height_i             0: 4 rows, 1: 8 rows, latched at start
//   busy_o, done_o       block in progress / one-cycle completion pulse
//   ref_rd_o, ref_addr_o reference row read (1-cycle sync SRAM)
//   ref_data_i           reference row, W+3 pixels, pixel 0 in LSBs
//   frac_x_o, frac_y_o   latched fractions to the filters
//   hor_pel_o            reference row passed straight to horizontal filters
//   hor_val_i            W horizontal results (2*PIXEL_WIDTH each)
//   ver_a_o..ver_d_o     vertical window, oldest row on ver_a_o
//   ver_pel_i            W vertical filter results
//   pred_wr_o, pred_addr_o, pred_data_o  prediction row write
//   dbg_state_o          current FSM state (IDLE=0, FETCH=1, DRAIN=2)
//
// Handshake: there is no flow control. A read request is answered by the
// SRAM one cycle later; a pred_wr_o strobe is always accepted.
module mc_chroma_filter_feeder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int W           = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start_i,
  input  logic [2:0]                     frac_x_i,
  input  logic [2:0]                     frac_y_i,
  input  logic                           height_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           ref_rd_o,
  output logic [3:0]                     ref_addr_o,
  input  logic [(W+3)*PIXEL_WIDTH-1:0]   ref_data_i,
  output logic [2:0]                     frac_x_o,
  output logic [2:0]                     frac_y_o,
  output logic [(W+3)*PIXEL_WIDTH-1:0]   hor_pel_o,
  input  logic [W*2*PIXEL_WIDTH-1:0]     hor_val_i,
  output logic [W*2*PIXEL_WIDTH-1:0]     ver_a_o,
  output logic [W*2*PIXEL_WIDTH-1:0]     ver_b_o,
  output logic [W*2*PIXEL_WIDTH-1:0]     ver_c_o,
  output logic [W*2*PIXEL_WIDTH-1:0]     ver_d_o,
  input  logic [W*PIXEL_WIDTH-1:0]       ver_pel_i,
  output logic                           pred_wr_o,
  output logic [2:0]                     pred_addr_o,
  output logic [W*PIXEL_WIDTH-1:0]       pred_data_o,
  output logic [1:0]                     dbg_state_o
);

  localparam int HW = W*2*PIXEL_WIDTH;
  localparam int PW = W*PIXEL_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [2:0]          frac_x_q, frac_x_d;
  logic [2:0]          frac_y_q, frac_y_d;
  logic                h8_q, h8_d;
  logic [3:0]          rd_cnt_q, rd_cnt_d;
  logic                rd_pend_q, rd_pend_d;   // SRAM data arrives this cycle
  logic                shifted_q, shifted_d;   // first cycle after a shift
  logic [3:0]          cap_cnt_q, cap_cnt_d;
  logic [3:0][HW-1:0]  win_q, win_d;           // entry 3 = newest row
  logic                pred_wr_q, pred_wr_d;
  logic [PW-1:0]       pred_data_q, pred_data_d;
  logic [2:0]          wr_cnt_q, wr_cnt_d;
  logic                done_q, done_d;

  logic [3:0] last_rd;
  logic [2:0] last_wr;
  logic       win_valid;
  logic       last_write;

  assign last_rd    = h8_q ? 4'd10 : 4'd6;
  assign last_wr    = h8_q ? 3'd7  : 3'd3;
  // Four rows captured and the newest one just arrived.
  assign win_valid  = shifted_q && (cap_cnt_q >= 4'd4);
  assign last_write = pred_wr_q && (wr_cnt_q == last_wr);

  always_comb begin
    state_d     = state_q;
    frac_x_d    = frac_x_q;
    frac_y_d    = frac_y_q;
    h8_d        = h8_q;
    rd_cnt_d    = rd_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    win_d       = win_q;
    rd_pend_d   = (state_q == FETCH);
    shifted_d   = rd_pend_q;
    pred_wr_d   = win_valid;
    pred_data_d = win_valid ? ver_pel_i : pred_data_q;
    wr_cnt_d    = pred_wr_q ? wr_cnt_q + 3'd1 : wr_cnt_q;
    done_d      = last_write;

    if (rd_pend_q) begin
      win_d     = {hor_val_i, win_q[3], win_q[2], win_q[1]};
      cap_cnt_d = cap_cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = FETCH;
          frac_x_d  = frac_x_i;
          frac_y_d  = frac_y_i;
          h8_d      = height_i;
          rd_cnt_d  = 4'd0;
          cap_cnt_d = 4'd0;
          wr_cnt_d  = 3'd0;
        end
      end
      FETCH: begin
        rd_cnt_d = rd_cnt_q + 4'd1;
        if (rd_cnt_q == last_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      frac_x_q    <= '0;
      frac_y_q    <= '0;
      h8_q        <= 1'b0;
      rd_cnt_q    <= '0;
      rd_pend_q   <= 1'b0;
      shifted_q   <= 1'b0;
      cap_cnt_q   <= '0;
      win_q       <= '0;
      pred_wr_q   <= 1'b0;
      pred_data_q <= '0;
      wr_cnt_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frac_x_q    <= frac_x_d;
      frac_y_q    <= frac_y_d;
      h8_q        <= h8_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_pend_q   <= rd_pend_d;
      shifted_q   <= shifted_d;
      cap_cnt_q   <= cap_cnt_d;
      win_q       <= win_d;
      pred_wr_q   <= pred_wr_d;
      pred_data_q <= pred_data_d;
      wr_cnt_q    <= wr_cnt_d;
      done_q      <= done_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign ref_rd_o    = (state_q == FETCH);
  assign ref_addr_o  = (state_q == FETCH) ? rd_cnt_q : 4'd0;
  assign frac_x_o    = frac_x_q;
  assign frac_y_o    = frac_y_q;
  assign hor_pel_o   = ref_data_i;
  assign ver_a_o     = win_q[0];
  assign ver_b_o     = win_q[1];
  assign ver_c_o     = win_q[2];
  assign ver_d_o     = win_q[3];
  assign pred_wr_o   = pred_wr_q;
  assign pred_addr_o = wr_cnt_q;
  assign pred_data_o = pred_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mc_chroma_filter_feeder.sv
// Bench for mc_chroma_filter_feeder: SRAM model, 4-tap chroma filter models
// for the external filter instances, and a scoreboard of expected reads,
// prediction writes and done pulses keyed by absolute cycle number.
module tb_mc_chroma_filter_feeder;
  localparam int PWID = 8;
  localparam int W    = 8;
  localparam int RW   = (W+3)*PWID;
  localparam int HW   = W*2*PWID;
  localparam int PW   = W*PWID;

  logic            clk, rstn, start_i, height_i;
  logic [2:0]      frac_x_i, frac_y_i, frac_x_o, frac_y_o;
  logic            busy_o, done_o, ref_rd_o, pred_wr_o;
  logic [3:0]      ref_addr_o;
  logic [RW-1:0]   ref_data_i, hor_pel_o;
  logic [HW-1:0]   hor_val_i, ver_a_o, ver_b_o, ver_c_o, ver_d_o;
  logic [PW-1:0]   ver_pel_i, pred_data_o;
  logic [2:0]      pred_addr_o;
  logic [1:0]      dbg_state_o;

  mc_chroma_filter_feeder #(.PIXEL_WIDTH(PWID), .W(W)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .frac_x_i(frac_x_i),
    .frac_y_i(frac_y_i), .height_i(height_i), .busy_o(busy_o),
    .done_o(done_o), .ref_rd_o(ref_rd_o), .ref_addr_o(ref_addr_o),
    .ref_data_i(ref_data_i), .frac_x_o(frac_x_o), .frac_y_o(frac_y_o),
    .hor_pel_o(hor_pel_o), .hor_val_i(hor_val_i), .ver_a_o(ver_a_o),
    .ver_b_o(ver_b_o), .ver_c_o(ver_c_o), .ver_d_o(ver_d_o),
    .ver_pel_i(ver_pel_i), .pred_wr_o(pred_wr_o), .pred_addr_o(pred_addr_o),
    .pred_data_o(pred_data_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment models ----------------
  logic [RW-1:0] ref_mem [0:10];
  always @(posedge clk) if (ref_rd_o) ref_data_i <= ref_mem[ref_addr_o];

  function automatic int coef(input logic [2:0] f, input int j);
    int t [8][4] = '{'{0,64,0,0},   '{-2,58,10,-2}, '{-4,54,16,-2},
                     '{-6,46,28,-4}, '{-4,36,36,-4}, '{-4,28,46,-6},
                     '{-2,16,54,-4}, '{-2,10,58,-2}};
    return t[f][j];
  endfunction

  function automatic int clip8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [HW-1:0] hfilt(input logic [RW-1:0] pel, input logic [2:0] f);
    logic [HW-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      int s;
      s = 0;
      for (int m = 0; m < 4; m++) s += coef(f, m) * int'(pel[(k+m)*PWID +: PWID]);
      r[k*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] vfilt(input logic [HW-1:0] a, b, c, d, input logic [2:0] f);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      int s;
      s = coef(f,0)*int'($signed(a[k*16 +: 16])) + coef(f,1)*int'($signed(b[k*16 +: 16]))
        + coef(f,2)*int'($signed(c[k*16 +: 16])) + coef(f,3)*int'($signed(d[k*16 +: 16]));
      s = clip8((s + 2048) >>> 12);
      r[k*PWID +: PWID] = s[7:0];
    end
    return r;
  endfunction

  assign hor_val_i = hfilt(hor_pel_o, frac_x_o);
  assign ver_pel_i = vfilt(ver_a_o, ver_b_o, ver_c_o, ver_d_o, frac_y_o);

  // ---------------- golden row model ----------------
  function automatic int pix(input int r, input int k);
    return int'(ref_mem[r][k*PWID +: PWID]);
  endfunction

  function automatic logic [PW-1:0] gold_row(input int i, input logic [2:0] fx, fy);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      int v;
      v = 0;
      for (int j = 0; j < 4; j++) begin
        int h;
        h = 0;
        for (int m = 0; m < 4; m++) h += coef(fx, m) * pix(i+j, k+m);
        v += coef(fy, j) * h;
      end
      v = clip8((v + 2048) >>> 12);
      r[k*PWID +: PWID] = v[7:0];
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [98:0] exp_q[$];   // {cycle, pred_addr, pred_data}
  logic [35:0] rd_q[$];    // {cycle, ref_addr}
  int          done_q[$];  // cycle of done_o
  int          n_tests = 0;
  int          n_fail  = 0;
  int          t0      = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    rd_q.delete();
    done_q.delete();
  endtask

  // Monitor: sampled on the falling edge, pops whatever the DUT presents.
  always @(negedge clk) begin
    if (rstn) begin
      if (ref_rd_o) begin
        if (rd_q.size() == 0) check("unexpected_rd", 1, 0);
        else begin
          logic [35:0] e;
          e = rd_q.pop_front();
          check("rd_addr", ref_addr_o, e[3:0]);
          check("rd_cycle", cyc, e[35:4]);
        end
      end
      if (pred_wr_o) begin
        if (exp_q.size() == 0) check("unexpected_wr", 1, 0);
        else begin
          logic [98:0] e;
          e = exp_q.pop_front();
          check("wr_addr", pred_addr_o, e[66:64]);
          check("wr_data", pred_data_o, e[63:0]);
          check("wr_cycle", cyc, e[98:67]);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
        check("busy_at_done", busy_o, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // kind 0: flat 100, 1: row r pixel k = 10r+k, 2: 0/255 checkerboard
  task automatic fill(input int kind);
    for (int r = 0; r < 11; r++)
      for (int k = 0; k < W+3; k++) begin
        int v;
        v = (kind == 0) ? 100 : (kind == 1) ? 10*r + k : (((r + k) % 2) != 0 ? 255 : 0);
        ref_mem[r][k*PWID +: PWID] = v[7:0];
      end
  endtask

  // Called at a falling edge. exp_kind 0: all 100, 1: integer-MV formula,
  // 2: all 128 (checkerboard, frac 4/4), 3: golden model.
  task automatic start_block(input logic [2:0] fx, fy, input logic h8, input int exp_kind);
    int h;
    h        = h8 ? 8 : 4;
    start_i  = 1'b1;
    frac_x_i = fx;
    frac_y_i = fy;
    height_i = h8;
    t0       = cyc;
    for (int r = 0; r < h + 3; r++) rd_q.push_back({32'(t0 + 1 + r), 4'(r)});
    for (int i = 0; i < h; i++) begin
      logic [PW-1:0] row;
      for (int k = 0; k < W; k++) begin
        int v;
        v = (exp_kind == 0) ? 100 : (exp_kind == 1) ? 10*(i+1) + (k+1) : 128;
        row[k*PWID +: PWID] = v[7:0];
      end
      if (exp_kind == 3) row = gold_row(i, fx, fy);
      exp_q.push_back({32'(t0 + 7 + i), 3'(i), row});
    end
    done_q.push_back(t0 + 7 + h);
    @(negedge clk);
    start_i  = 1'b0;
    frac_x_i = 3'($urandom_range(0, 7));
    frac_y_i = 3'($urandom_range(0, 7));
    height_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || done_q.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d writes still outstanding after 80 cycles", exp_q.size());
      flush();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 80);
    if (!done_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: done_o not seen within 80 cycles");
      flush();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_rd"},    ref_rd_o, 0);
    check({tag, "_raddr"}, ref_addr_o, 0);
    check({tag, "_wr"},    pred_wr_o, 0);
    check({tag, "_waddr"}, pred_addr_o, 0);
    check({tag, "_wdata"}, pred_data_o, 0);
    check({tag, "_vera"},  ver_a_o, 0);
    check({tag, "_verd"},  ver_d_o, 0);
    check({tag, "_frac"},  {frac_x_o, frac_y_o}, 0);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn     = 1'b0;
    start_i  = 1'b0;
    frac_x_i = '0;
    frac_y_i = '0;
    height_i = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_horpel", hor_pel_o, ref_data_i);
    rstn = 1'b1;
    @(negedge clk);

    // Flat reference, fractional MV
    fill(0);
    start_block(3'd3, 3'd5, 1'b0, 0);
    wait_idle();
    repeat (2) @(negedge clk);

    // Integer MV on a ramp, 8 rows
    fill(1);
    start_block(3'd0, 3'd0, 1'b1, 1);
    wait_idle();
    repeat (2) @(negedge clk);

    // Checkerboard, then back-to-back blocks (start in the done cycle)
    fill(2);
    start_block(3'd4, 3'd4, 1'b0, 2);
    wait_done();
    start_block(3'd4, 3'd4, 1'b1, 2);
    wait_done();
    start_block(3'd2, 3'd6, 1'b0, 3);
    wait_idle();
    repeat (2) @(negedge clk);

    // Start while busy is ignored
    fill(1);
    start_block(3'd3, 3'd5, 1'b0, 3);
    @(negedge clk);
    start_i  = 1'b1;
    frac_x_i = 3'd7;
    frac_y_i = 3'd1;
    height_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Reset in cycle 8 of an 8-row block
    fill(1);
    start_block(3'd0, 3'd0, 1'b1, 1);
    while (cyc != t0 + 8) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_pending_rows", exp_q.size(), 7);
    flush();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", busy_o, 0);
    start_block(3'd0, 3'd0, 1'b1, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
